// File: rtl/down_counter_timer.sv
// Loadable down counter / interval timer with a one-cycle done pulse on expiry.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to make it a periodic timer that reloads on expiry.
module down_counter_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_r;
   logic [WIDTH-1:0] count_r;
   logic             busy_r;
   logic             done_r;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_r;
`endif

   // Timer state machine: load has priority over enable in both states.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         count_r  <= ZERO_C;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
         reload_r <= ZERO_C;
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (load) begin
                  count_r <= load_value;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                  reload_r <= load_value;
`endif
                  if (load_value != ZERO_C) begin
                     state_r <= RUN;
                     busy_r  <= 1'b1;
                  end else begin
                     // A zero-length timer expires on the load edge itself.
                     done_r  <= 1'b1;
                  end
               end else begin
                  count_r <= count_r;
               end
            end
            RUN: begin
               if (load) begin
                  count_r <= load_value;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                  reload_r <= load_value;
`endif
                  if (load_value == ZERO_C) begin
                     done_r  <= 1'b1;
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end else begin
                     busy_r  <= 1'b1;
                  end
               end else if (enable) begin
                  if (count_r == ONE_C) begin
                     done_r  <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                     count_r <= reload_r;
`else
                     count_r <= ZERO_C;
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
`endif
                  end else if (count_r != ZERO_C) begin
                     count_r <= count_r - ONE_C;
                  end else begin
                     // Unreachable in normal operation; recover to IDLE without wrapping.
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  count_r <= count_r;
               end
            end
            default: begin
               state_r <= IDLE;
               count_r <= ZERO_C;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign count = count_r;
   assign zero  = (count_r == ZERO_C);
   assign busy  = busy_r;
   assign done  = done_r;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH = 4).
// Auto-reload checks run only when DOWN_COUNTER_AUTO_RELOAD_EN is defined.
module tb_down_counter_timer;

   localparam int WIDTH = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             enable;
   logic [WIDTH-1:0] count;
   logic             zero;
   logic             busy;
   logic             done;

   int check_count = 0;
   int fail_count  = 0;

   down_counter_timer #(.WIDTH(WIDTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .enable     (enable),
      .count      (count),
      .zero       (zero),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [3:0] en_seq  [6] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1};
      logic [3:0] gate_exp[6] = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0};
      int done_seen;
      int done_edge;

      reset = 1'b1; load = 1'b0; load_value = 4'd0; enable = 1'b0;
      tick();
      check_value("rst_count", count, 32'd0);
      check_value("rst_zero",  zero,  32'd1);
      check_value("rst_busy",  busy,  32'd0);
      check_value("rst_done",  done,  32'd0);
      reset = 1'b0;
      tick();

      // Basic one-shot: load 3 with enable held high.
      load = 1'b1; load_value = 4'd3; enable = 1'b1;
      tick();
      load = 1'b0;
      check_value("os_load_count", count, 32'd3);
      check_value("os_load_busy",  busy,  32'd1);
      check_value("os_load_done",  done,  32'd0);
      tick();
      check_value("os_c2", count, 32'd2);
      tick();
      check_value("os_c1",    count, 32'd1);
      check_value("os_c1_dn", done,  32'd0);
      tick();
      check_value("os_c0",      count, 32'd0);
      check_value("os_done",    done,  32'd1);
      check_value("os_busy_lo", busy,  32'd0);
      check_value("os_zero",    zero,  32'd1);
      tick();
      check_value("os_done_1cyc", done, 32'd0);

      // Enable gating.
      enable = 1'b0; load = 1'b1; load_value = 4'd4;
      tick();
      load = 1'b0;
      check_value("gate_load", count, 32'd4);
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         enable = en_seq[i][0];
         tick();
         check_value($sformatf("gate_c%0d", i), count, {28'd0, gate_exp[i]});
         if (done) done_seen++;
      end
      check_value("gate_done_once", done_seen, 32'd1);
      check_value("gate_busy_lo",   busy,      32'd0);

      // Load priority at count == 1.
      enable = 1'b1; load = 1'b1; load_value = 4'd2;
      tick();
      load = 1'b0;
      tick();
      check_value("prio_pre", count, 32'd1);
      load = 1'b1; load_value = 4'd9;
      tick();
      load = 1'b0;
      check_value("prio_count", count, 32'd9);
      check_value("prio_done",  done,  32'd0);
      check_value("prio_busy",  busy,  32'd1);

      // Asynchronous reset mid-run at count 5.
      enable = 1'b0; load = 1'b1; load_value = 4'd5;
      tick();
      load = 1'b0;
      check_value("arst_pre_count", count, 32'd5);
      check_value("arst_pre_busy",  busy,  32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_value("arst_count", count, 32'd0);
      check_value("arst_busy",  busy,  32'd0);
      check_value("arst_zero",  zero,  32'd1);
      check_value("arst_done",  done,  32'd0);
      enable = 1'b1;
      tick();
      check_value("arst_hold_done", done, 32'd0);
      reset = 1'b0;
      enable = 1'b0;
      tick();
      check_value("arst_after_done", done, 32'd0);

      // Zero load from IDLE.
      load = 1'b1; load_value = 4'd0;
      tick();
      load = 1'b0;
      check_value("z_done",  done,  32'd1);
      check_value("z_busy",  busy,  32'd0);
      check_value("z_count", count, 32'd0);
      tick();
      check_value("z_done_1cyc", done, 32'd0);

      // No underflow in IDLE with enable high.
      enable = 1'b1;
      tick();
      tick();
      check_value("nowrap_count", count, 32'd0);
      check_value("nowrap_done",  done,  32'd0);
      check_value("nowrap_busy",  busy,  32'd0);

      // Maximum load: done after exactly 15 enabled edges.
      load = 1'b1; load_value = 4'd15;
      tick();
      load = 1'b0;
      check_value("max_load", count, 32'd15);
      done_edge = 0;
      for (int i = 1; i <= 40 && done_edge == 0; i++) begin
         tick();
         if (done) done_edge = i;
      end
      check_value("max_latency", done_edge, 32'd15);
      check_value("max_count",   count,     32'd0);

      // Load of zero while running.
      load = 1'b1; load_value = 4'd6;
      tick();
      load_value = 4'd0;
      tick();
      load = 1'b0;
      check_value("runz_done",  done,  32'd1);
      check_value("runz_busy",  busy,  32'd0);
      check_value("runz_count", count, 32'd0);
      tick();

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      begin
         logic [3:0] ar_exp[10] = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
         enable = 1'b1; load = 1'b1; load_value = 4'd3;
         for (int i = 0; i < 10; i++) begin
            tick();
            load = 1'b0;
            check_value($sformatf("ar_c%0d", i), count, {28'd0, ar_exp[i]});
            check_value($sformatf("ar_d%0d", i), done,
                        (i == 3 || i == 6 || i == 9) ? 32'd1 : 32'd0);
            check_value($sformatf("ar_b%0d", i), busy, 32'd1);
         end
         load = 1'b1; load_value = 4'd0;
         tick();
         load = 1'b0;
         check_value("ar_stop_done", done, 32'd1);
         check_value("ar_stop_busy", busy, 32'd0);
         tick();
         check_value("ar_idle_count", count, 32'd0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
